// File: rtl/display_pkg.sv
// Shared display definitions: segment patterns, BCD FSM states and
// helper functions used by the Gray display path.
package display_pkg;

  localparam int SEG_W = 7;

  // {a,b,c,d,e,f,g}, active-high; entry 0 is the rightmost element.
  localparam logic [9:0][SEG_W-1:0] SEG_LUT = {
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_fsm_e;

  // Gray to binary for up to 16 bits; zero-extended inputs give the
  // correct result in the low bits because leading zeros do not flip.
  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Number of decimal digits needed to hold 2^w - 1.
  function automatic int dec_digits(input int w);
    int v;
    int d;
    v = (1 << w) - 1;
    d = 1;
    for (int k = 0; k < 5; k++) begin
      if (v >= 10) begin
        v = v / 10;
        d = d + 1;
      end
    end
    return d;
  endfunction

  // Decimal digit to segments; non-decimal nibbles show a dash.
  function automatic logic [SEG_W-1:0] seg_of(input logic [3:0] d);
    if (d > 4'd9) begin
      return SEG_DASH;
    end
    return SEG_LUT[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter. One SHIFT cycle per input bit,
// then a one-cycle DONE where the result register is valid. A new start
// during a conversion is remembered (latest value only) and converted
// straight after DONE.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);

  bcd_fsm_e              r_state;
  logic [BW+WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]      r_latest;
  logic                  r_pend;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bcd;
  logic                  r_busy;
  logic                  r_done;

  logic [BW+WIDTH-1:0]   w_adj;
  logic [BW+WIDTH-1:0]   w_step;

  // Add-3 correction on every BCD nibble that is 5 or more.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      logic [3:0] w_nib;
      assign w_nib = r_shift[WIDTH+4*gi +: 4];
      assign w_adj[WIDTH+4*gi +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end
  endgenerate

  assign w_adj[WIDTH-1:0] = r_shift[WIDTH-1:0];
  assign w_step           = {w_adj[BW+WIDTH-2:0], 1'b0};

  // Conversion FSM with registered busy/done and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_latest <= '0;
      r_pend   <= 1'b0;
      r_cnt    <= '0;
      r_bcd    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= {{BW{1'b0}}, bin};
            r_cnt   <= '0;
            r_state <= SHIFT;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          r_shift <= w_step;
          if (start) begin
            r_pend   <= 1'b1;
            r_latest <= bin;
          end
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= DONE;
            r_bcd   <= w_step[BW+WIDTH-1:WIDTH];
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_cnt <= '0;
          if (start) begin
            // A value arriving right now is newer than any pending one.
            r_shift <= {{BW{1'b0}}, bin};
            r_pend  <= 1'b0;
            r_state <= SHIFT;
          end else if (r_pend) begin
            r_shift <= {{BW{1'b0}}, r_latest};
            r_pend  <= 1'b0;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: rtl/gray_seg_display_mux.sv
// Gray switch inputs to debounced binary LEDs and a multiplexed
// common-cathode 7-segment display with leading-zero blanking and
// overflow dashes.
module gray_seg_display_mux
  import display_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 2,
  parameter int DEB_CYCLES  = 270000,
  parameter int REFRESH_DIV = 27000,
  parameter int BLANK_LZ    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  gray_in,
  output logic [WIDTH-1:0]  led,
  output logic [WIDTH-1:0]  bin_out,
  output logic              bcd_busy,
  output logic [SEG_W-1:0]  seg,
  output logic [DIGITS-1:0] dig_en
);

  // Converter is sized for every value WIDTH bits can hold, so digits
  // beyond DIGITS are available to flag overflow.
  localparam int NBCD = (dec_digits(WIDTH) > DIGITS) ? dec_digits(WIDTH) : DIGITS;
  localparam int DW   = (DEB_CYCLES > 1)  ? $clog2(DEB_CYCLES)  : 1;
  localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW   = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;

  logic [WIDTH-1:0]  r_sync1;
  logic [WIDTH-1:0]  r_sync2;
  logic [WIDTH-1:0]  r_prev;
  logic [DW-1:0]     r_deb_cnt;
  logic [WIDTH-1:0]  r_accepted;
  logic [WIDTH-1:0]  r_bin;

  logic [4*DIGITS-1:0] r_disp;
  logic                r_ovf;

  logic [RW-1:0]     r_ref_cnt;
  logic [IW-1:0]     r_dig_idx;
  logic [SEG_W-1:0]  r_seg;
  logic [DIGITS-1:0] r_dig_en;

  logic              w_accept;
  logic [WIDTH-1:0]  w_bin_new;
  logic              w_busy;
  logic              w_done;
  logic [4*NBCD-1:0] w_bcd;
  logic              w_ovf_now;
  logic [3:0]        w_nib [DIGITS];
  logic [DIGITS-1:0] w_zero_above;
  logic [3:0]        w_cur_nib;
  logic              w_cur_lz;
  logic [SEG_W-1:0]  w_seg_next;

  // Accept once the synchronised value has held for DEB_CYCLES samples
  // and differs from what is already shown.
  assign w_accept  = (r_sync2 == r_prev) &&
                     (r_deb_cnt == DW'(DEB_CYCLES - 1)) &&
                     (r_sync2 != r_accepted);
  assign w_bin_new = WIDTH'(gray2bin(16'(r_sync2)));

  // Two-flop synchroniser, stability counter and accepted value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_deb_cnt  <= '0;
      r_accepted <= '0;
      r_bin      <= '0;
    end else begin
      r_sync1 <= gray_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_sync2 != r_prev) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt != DW'(DEB_CYCLES - 1)) begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
      if (w_accept) begin
        r_accepted <= r_sync2;
        r_bin      <= w_bin_new;
      end
    end
  end

  // The converter loads the new binary on the same edge that updates
  // the LEDs, so it always works on the value about to be shown.
  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (NBCD)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_accept),
    .bin   (w_bin_new),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  genvar gi;
  generate
    if (NBCD > DIGITS) begin : g_ovf
      assign w_ovf_now = |w_bcd[4*NBCD-1:4*DIGITS];
    end else begin : g_no_ovf
      assign w_ovf_now = 1'b0;
    end

    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_nib[gi]        = r_disp[4*gi +: 4];
      assign w_zero_above[gi] = (r_disp[4*DIGITS-1:4*gi] == '0);
    end
  endgenerate

  // Display copy changes only on a finished conversion, never mid-way.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp <= '0;
      r_ovf  <= 1'b0;
    end else if (w_done) begin
      r_disp <= w_bcd[4*DIGITS-1:0];
      r_ovf  <= w_ovf_now;
    end
  end

  // Pick the nibble and leading-zero status of the digit being driven.
  always_comb begin
    w_cur_nib = 4'd0;
    w_cur_lz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_dig_idx == IW'(i)) begin
        w_cur_nib = w_nib[i];
        w_cur_lz  = (i != 0) && w_zero_above[i];
      end
    end
  end

  // Segment pattern for the active digit: overflow, blank, or decimal.
  always_comb begin
    w_seg_next = seg_of(w_cur_nib);
    if (r_ovf) begin
      w_seg_next = SEG_DASH;
    end else if ((BLANK_LZ != 0) && w_cur_lz) begin
      w_seg_next = SEG_BLANK;
    end
  end

  // Refresh timing; seg and dig_en are registered together so they
  // always switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt <= '0;
      r_dig_idx <= '0;
      r_seg     <= '0;
      r_dig_en  <= '0;
    end else begin
      r_seg    <= w_seg_next;
      r_dig_en <= DIGITS'(1) << r_dig_idx;
      if (r_ref_cnt == RW'(REFRESH_DIV - 1)) begin
        r_ref_cnt <= '0;
        r_dig_idx <= (r_dig_idx == IW'(DIGITS - 1)) ? '0 : (r_dig_idx + 1'b1);
      end else begin
        r_ref_cnt <= r_ref_cnt + 1'b1;
      end
    end
  end

  assign led      = r_bin;
  assign bin_out  = r_bin;
  assign bcd_busy = w_busy;
  assign seg      = r_seg;
  assign dig_en   = r_dig_en;

endmodule

// File: tb/tb_gray_seg_display_mux.sv
// Self-checking bench: three instances share the switch stimulus
// (default blanking, no blanking, single digit). LED updates are
// scoreboarded through a queue; display checks sample seg per digit.
module tb_gray_seg_display_mux;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SBLANK = 7'b0000000;
  localparam logic [6:0] SDASH  = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;

  logic [3:0] led_m, bin_m, led_n, bin_n, led_o, bin_o;
  logic       busy_m, busy_n, busy_o;
  logic [6:0] seg_m, seg_n, seg_o;
  logic [1:0] en_m, en_n;
  logic [0:0] en_o;

  int checks = 0;
  int errors = 0;
  int cons_bad = 0;
  int exp_led_q[$];

  always #5 clk = ~clk;

  gray_seg_display_mux #(.WIDTH(4), .DIGITS(2), .DEB_CYCLES(4), .REFRESH_DIV(8), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .led(led_m), .bin_out(bin_m),
    .bcd_busy(busy_m), .seg(seg_m), .dig_en(en_m));

  gray_seg_display_mux #(.WIDTH(4), .DIGITS(2), .DEB_CYCLES(4), .REFRESH_DIV(8), .BLANK_LZ(0)) u_dut_nb (
    .clk(clk), .rst(rst), .gray_in(gray_in), .led(led_n), .bin_out(bin_n),
    .bcd_busy(busy_n), .seg(seg_n), .dig_en(en_n));

  gray_seg_display_mux #(.WIDTH(4), .DIGITS(1), .DEB_CYCLES(4), .REFRESH_DIV(8), .BLANK_LZ(1)) u_dut_one (
    .clk(clk), .rst(rst), .gray_in(gray_in), .led(led_o), .bin_out(bin_o),
    .bcd_busy(busy_o), .seg(seg_o), .dig_en(en_o));

  // Reference conversion written as a closed-form XOR of shifts.
  function automatic int gray_to_int(input logic [3:0] g);
    logic [3:0] b;
    b = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    return int'(b);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] g);
    gray_in = g;
    exp_led_q.push_back(gray_to_int(g));
  endtask

  // Wait (bounded) for a given digit to be enabled and return its seg.
  task automatic get_seg(input int sel, input int digit, output logic [6:0] s, output bit found);
    found = 1'b0;
    s = 'x;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      case (sel)
        0: if (en_m == 2'(1 << digit)) begin s = seg_m; found = 1'b1; end
        1: if (en_n == 2'(1 << digit)) begin s = seg_n; found = 1'b1; end
        default: if (en_o == 1'b1) begin s = seg_o; found = 1'b1; end
      endcase
    end
  endtask

  // Scoreboard: every LED change is popped against the queued value.
  initial begin : mon
    logic [3:0] prev;
    int e;
    prev = 4'd0;
    forever begin
      @(negedge clk);
      if (led_n !== led_m || led_o !== led_m || bin_n !== led_m || bin_o !== led_m ||
          bin_m !== led_m || busy_n !== busy_m || busy_o !== busy_m || en_n !== en_m)
        cons_bad++;
      if (rst) begin
        prev = led_m;
      end else if (led_m !== prev) begin
        prev = led_m;
        checks++;
        if (exp_led_q.size() == 0) begin
          errors++;
          $display("FAIL led_txn unexpected change got %0d required none", led_m);
        end else begin
          e = exp_led_q.pop_front();
          if (led_m !== 4'(e)) begin
            errors++;
            $display("FAIL led_txn got %0d required %0d", led_m, e);
          end else begin
            $display("txn led=%0d", led_m);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    gray_in = 4'b1111;
    step(3);
    checks++;
    if (led_m !== 4'd0 || bin_m !== 4'd0 || seg_m !== 7'd0 || en_m !== 2'd0 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_state led=%0d seg=%b en=%b busy=%b required 0", led_m, seg_m, en_m, busy_m);
    end
    rst = 1'b0;
    gray_in = 4'b0000;
    step(1);
    checks++;
    if (en_m !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_digit got %b required 01", en_m);
    end
    checks++;
    if (seg_m !== S0) begin
      errors++;
      $display("FAIL reset_first_seg got %b required %b", seg_m, S0);
    end
  endtask

  task automatic test_debounce_accept();
    logic [6:0] s;
    bit f;
    drive(4'b1000);
    step(6);
    checks++;
    if (led_m !== 4'd0) begin
      errors++;
      $display("FAIL deb_early got %0d required 0", led_m);
    end
    step(1);
    checks++;
    if (led_m !== 4'd15 || bin_m !== 4'd15) begin
      errors++;
      $display("FAIL deb_latency led=%0d bin=%0d required 15", led_m, bin_m);
    end
    step(12);
    get_seg(0, 0, s, f);
    checks++;
    if (!f || s !== S5) begin
      errors++;
      $display("FAIL deb_units got %b required %b", s, S5);
    end
    get_seg(0, 1, s, f);
    checks++;
    if (!f || s !== S1) begin
      errors++;
      $display("FAIL deb_tens got %b required %b", s, S1);
    end
  endtask

  task automatic test_glitch_reject();
    bit busy_seen;
    drive(4'b0000);
    step(14);
    checks++;
    if (busy_m !== 1'b0) begin
      errors++;
      $display("FAIL glitch_pre_idle busy=%b required 0", busy_m);
    end
    busy_seen = 1'b0;
    gray_in = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (busy_m) busy_seen = 1'b1;
    end
    gray_in = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (busy_m) busy_seen = 1'b1;
    end
    checks++;
    if (led_m !== 4'd0 || busy_seen) begin
      errors++;
      $display("FAIL glitch_reject led=%0d busy_seen=%0d required 0/0", led_m, busy_seen);
    end
  endtask

  task automatic test_blanking();
    logic [6:0] s;
    bit f;
    drive(4'b0101);
    step(16);
    get_seg(0, 0, s, f);
    checks++;
    if (!f || s !== S6) begin
      errors++;
      $display("FAIL lz_units got %b required %b", s, S6);
    end
    get_seg(0, 1, s, f);
    checks++;
    if (!f || s !== SBLANK) begin
      errors++;
      $display("FAIL lz_tens_blank got %b required %b", s, SBLANK);
    end
    get_seg(1, 1, s, f);
    checks++;
    if (!f || s !== S0) begin
      errors++;
      $display("FAIL nolz_tens got %b required %b", s, S0);
    end
    get_seg(2, 0, s, f);
    checks++;
    if (!f || s !== S6) begin
      errors++;
      $display("FAIL one_digit_six got %b required %b", s, S6);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] s;
    bit f;
    bit busy_prev;
    int rises, busy_cycles, bad;
    rises = 0;
    busy_cycles = 0;
    bad = 0;
    busy_prev = busy_m;
    drive(4'b1101);
    for (int i = 0; i < 35; i++) begin
      if (i == 5) drive(4'b1010);
      step(1);
      if (busy_m && !busy_prev) rises++;
      if (busy_m) busy_cycles++;
      busy_prev = busy_m;
      if (en_m == 2'b01 && seg_m !== S6 && seg_m !== S9 && seg_m !== S2) bad++;
      if (en_m == 2'b10 && seg_m !== SBLANK && seg_m !== S1) bad++;
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL b2b_busy_rises got %0d required 1", rises);
    end
    checks++;
    if (busy_cycles != 10) begin
      errors++;
      $display("FAIL b2b_busy_cycles got %0d required 10", busy_cycles);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_intermediate got %0d bad samples required 0", bad);
    end
    get_seg(0, 0, s, f);
    checks++;
    if (!f || s !== S2) begin
      errors++;
      $display("FAIL b2b_units got %b required %b", s, S2);
    end
    get_seg(0, 1, s, f);
    checks++;
    if (!f || s !== S1) begin
      errors++;
      $display("FAIL b2b_tens got %b required %b", s, S1);
    end
  endtask

  task automatic test_overflow();
    logic [6:0] s;
    bit f;
    drive(4'b1111);
    step(16);
    get_seg(2, 0, s, f);
    checks++;
    if (!f || s !== SDASH) begin
      errors++;
      $display("FAIL ovf_dash got %b required %b", s, SDASH);
    end
    get_seg(0, 0, s, f);
    checks++;
    if (!f || s !== S0) begin
      errors++;
      $display("FAIL ten_units got %b required %b", s, S0);
    end
    get_seg(0, 1, s, f);
    checks++;
    if (!f || s !== S1) begin
      errors++;
      $display("FAIL ten_tens got %b required %b", s, S1);
    end
  endtask

  task automatic test_refresh();
    int last, n;
    logic [1:0] prev_en;
    last = -1;
    n = 0;
    prev_en = en_m;
    for (int c = 0; c < 60; c++) begin
      step(1);
      if (en_m !== prev_en) begin
        if (last >= 0) begin
          checks++;
          if ((c - last) != 8 || en_m !== ~prev_en) begin
            errors++;
            $display("FAIL refresh_period got %0d cycles en=%b required 8 en=%b", c - last, en_m, ~prev_en);
          end
        end
        last = c;
        n++;
        prev_en = en_m;
      end
    end
    checks++;
    if (n < 6) begin
      errors++;
      $display("FAIL refresh_count got %0d switches required >=6", n);
    end
  endtask

  task automatic test_rst_mid_shift();
    bit seen;
    seen = 1'b0;
    drive(4'b0111);
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (busy_m) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_mid_wait busy never rose required 1");
    end
    step(1);
    rst = 1'b1;
    gray_in = 4'b0000;
    step(1);
    checks++;
    if (busy_m !== 1'b0 || led_m !== 4'd0 || seg_m !== 7'd0 || en_m !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_abort busy=%b led=%0d seg=%b en=%b required 0", busy_m, led_m, seg_m, en_m);
    end
    rst = 1'b0;
    step(10);
    checks++;
    if (busy_m !== 1'b0 || led_m !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_after busy=%b led=%0d required 0", busy_m, led_m);
    end
  endtask

  initial begin
    test_reset();
    test_debounce_accept();
    test_glitch_reject();
    test_blanking();
    test_back_to_back();
    test_overflow();
    test_refresh();
    test_rst_mid_shift();
    checks++;
    if (exp_led_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left required 0", exp_led_q.size());
    end
    checks++;
    if (cons_bad != 0) begin
      errors++;
      $display("FAIL instance_consistency got %0d bad cycles required 0", cons_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running required finished");
    $fatal(1, "watchdog");
  end

endmodule
